// File: rtl/axis_seq_generator_if.sv
// AXI4-Stream master/slave bundle used by the sequence generator.
interface axis_seq_generator_if #(
  parameter int DATA_SIZE = 32
);
  logic [DATA_SIZE-1:0]   tdata;
  logic [DATA_SIZE/8-1:0] tstrb;
  logic                   tvalid;
  logic                   tlast;
  logic                   tready;

  modport master (
    output tdata,
    output tstrb,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tstrb,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_seq_generator.sv
// AXI4-Stream sequence source: geometric, arithmetic, Galois LFSR or constant
// values in framed bursts. Configuration is captured when a run starts, so
// cfg_* may change freely while streaming.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for enable; cfg_* sampled on the way out
// S_STREAM | presenting beats; tvalid held high until each transfer
// S_DONE   | bounded run finished; parked until enable falls
module axis_seq_generator #(
  parameter int DATA_SIZE = 32,
  parameter int LEN_W     = 16
) (
  input  logic                 m00_axis_aclk,
  input  logic                 m00_axis_aresetn,
  input  logic                 m00_axis_enable,
  input  logic [1:0]           cfg_mode,
  input  logic [DATA_SIZE-1:0] cfg_seed,
  input  logic [DATA_SIZE-1:0] cfg_coef,
  input  logic [LEN_W-1:0]     cfg_frame_len,
  input  logic [LEN_W-1:0]     cfg_num_frames,
  input  logic                 cfg_restart,
  axis_seq_generator_if.master m00_axis,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  localparam int STRB_W = DATA_SIZE / 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    M_GEO   = 2'b00,
    M_ARITH = 2'b01,
    M_LFSR  = 2'b10,
    M_CONST = 2'b11
  } mode_t;

  state_t state_q, state_d;
  logic   done_d;

  // Run configuration captured at start
  mode_t                mode_q;
  logic [DATA_SIZE-1:0] seed_q;
  logic [DATA_SIZE-1:0] coef_q;
  logic [LEN_W-1:0]     len_m1_q;
  logic                 bounded_q;
  logic                 restart_q;

  // Beats left in the current frame and frames left in a bounded run, both
  // counting down; the terminal compare drives tlast and the run end.
  logic [LEN_W-1:0]     beats_left_q;
  logic [LEN_W-1:0]     frames_left_q;
  logic                 stop_q;

  logic [DATA_SIZE-1:0] value_q;
  logic                 valid_q;
  logic                 last_q;
  logic [STRB_W-1:0]    strb_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 ovf_q;

  logic [LEN_W-1:0]       len_m1_cfg;
  logic                   start;
  logic                   xfer;
  logic                   frame_end;
  logic                   run_final;
  logic                   stop_now;
  logic [2*DATA_SIZE-1:0] prod;
  logic [DATA_SIZE:0]     sum;
  logic [DATA_SIZE-1:0]   lfsr_next;
  logic [DATA_SIZE-1:0]   f_val;
  logic                   f_ovf;

  // A programmed frame length of 0 behaves as 1
  assign len_m1_cfg = (cfg_frame_len == '0) ? '0 : cfg_frame_len - LEN_W'(1);
  assign start      = (state_q == S_IDLE) && m00_axis_enable;
  assign xfer       = valid_q && m00_axis.tready;
  assign frame_end  = xfer && last_q;
  assign run_final  = bounded_q && (frames_left_q == LEN_W'(1));
  // Enable dropping anywhere in the frame (including on its last beat) ends
  // the run once that frame is out.
  assign stop_now   = stop_q || !m00_axis_enable;

  // Next sequence value and its overflow flag for the current mode
  always_comb begin
    prod      = {{DATA_SIZE{1'b0}}, value_q} * {{DATA_SIZE{1'b0}}, coef_q};
    sum       = {1'b0, value_q} + {1'b0, coef_q};
    lfsr_next = (value_q >> 1) ^ (value_q[0] ? coef_q : '0);
    f_val     = value_q;
    f_ovf     = 1'b0;
    case (mode_q)
      M_GEO: begin
        f_val = prod[DATA_SIZE-1:0];
        f_ovf = |prod[2*DATA_SIZE-1:DATA_SIZE];
      end
      M_ARITH: begin
        f_val = sum[DATA_SIZE-1:0];
        f_ovf = sum[DATA_SIZE];
      end
      M_LFSR:  f_val = lfsr_next;
      default: f_val = value_q;
    endcase
  end

  // State register
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) state_q <= S_IDLE;
    else                   state_q <= state_d;
  end

  // Next-state decode; a final bounded frame wins over an enable drop
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (m00_axis_enable) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (frame_end) begin
          if (run_final) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (stop_now) begin
            state_d = S_IDLE;
          end
        end
      end
      S_DONE: begin
        if (!m00_axis_enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Configuration capture, sequence advance, counters and registered outputs
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      mode_q        <= M_GEO;
      seed_q        <= '0;
      coef_q        <= '0;
      len_m1_q      <= '0;
      bounded_q     <= 1'b0;
      restart_q     <= 1'b0;
      beats_left_q  <= '0;
      frames_left_q <= '0;
      stop_q        <= 1'b0;
      value_q       <= '0;
      valid_q       <= 1'b0;
      last_q        <= 1'b0;
      strb_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      valid_q <= (state_d == S_STREAM);
      busy_q  <= (state_d == S_STREAM);
      strb_q  <= {STRB_W{state_d == S_STREAM}};
      done_q  <= done_d;
      stop_q  <= frame_end ? 1'b0
               : (stop_q || ((state_q == S_STREAM) && !m00_axis_enable));

      if (start) begin
        mode_q        <= mode_t'(cfg_mode);
        seed_q        <= cfg_seed;
        coef_q        <= cfg_coef;
        len_m1_q      <= len_m1_cfg;
        bounded_q     <= |cfg_num_frames;
        restart_q     <= cfg_restart;
        beats_left_q  <= len_m1_cfg;
        frames_left_q <= cfg_num_frames;
        stop_q        <= 1'b0;
        value_q       <= cfg_seed;
        last_q        <= (len_m1_cfg == '0);
        ovf_q         <= 1'b0;
      end else if (xfer) begin
        ovf_q <= ovf_q || f_ovf;
        if (last_q) begin
          value_q      <= restart_q ? seed_q : f_val;
          beats_left_q <= len_m1_q;
          last_q       <= (state_d == S_STREAM) && (len_m1_q == '0);
          if (bounded_q) frames_left_q <= frames_left_q - LEN_W'(1);
        end else begin
          value_q      <= f_val;
          beats_left_q <= beats_left_q - LEN_W'(1);
          last_q       <= (beats_left_q == LEN_W'(1));
        end
      end
    end
  end

  assign m00_axis.tdata  = value_q;
  assign m00_axis.tstrb  = strb_q;
  assign m00_axis.tvalid = valid_q;
  assign m00_axis.tlast  = last_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign overflow        = ovf_q;

endmodule

// File: tb/tb_axis_seq_generator.sv
// Bench for axis_seq_generator: directed scenarios plus randomized runs,
// checked cycle by cycle against a beat/frame-level reference model.
module tb_axis_seq_generator;

  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [1:0]    cfg_mode;
  logic [DW-1:0] cfg_seed;
  logic [DW-1:0] cfg_coef;
  logic [LW-1:0] cfg_frame_len;
  logic [LW-1:0] cfg_num_frames;
  logic          cfg_restart;
  logic          busy;
  logic          done;
  logic          overflow;

  axis_seq_generator_if #(.DATA_SIZE(DW)) ax ();

  axis_seq_generator #(.DATA_SIZE(DW), .LEN_W(LW)) dut (
    .m00_axis_aclk    (clk),
    .m00_axis_aresetn (rst_n),
    .m00_axis_enable  (en),
    .cfg_mode         (cfg_mode),
    .cfg_seed         (cfg_seed),
    .cfg_coef         (cfg_coef),
    .cfg_frame_len    (cfg_frame_len),
    .cfg_num_frames   (cfg_num_frames),
    .cfg_restart      (cfg_restart),
    .m00_axis         (ax),
    .busy             (busy),
    .done             (done),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: run phase (0 idle, 1 streaming, 2 finished) plus the
  // current value, beat index within the frame and frames emitted.
  int            m_phase;
  logic [1:0]    m_mode;
  logic [DW-1:0] m_seed, m_coef, m_v;
  int            m_len, m_nfr, m_beat, m_frame;
  logic          m_restart, m_ovf, m_drop, m_done;

  logic [DW-1:0] got_q [$];
  logic          got_l [$];
  logic [DW-1:0] exp_v [$];
  logic          exp_l [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_val(input logic [1:0] mode, input logic [DW-1:0] v,
                          input logic [DW-1:0] c, output logic [DW-1:0] nv,
                          output logic no);
    logic [63:0] p;
    logic [32:0] s;
    p  = 64'(v) * 64'(c);
    s  = 33'(v) + 33'(c);
    nv = v;
    no = 1'b0;
    case (mode)
      2'b00: begin nv = p[31:0]; no = (p[63:32] != 32'd0); end
      2'b01: begin nv = s[31:0]; no = s[32]; end
      2'b10: nv = (v >> 1) ^ (v[0] ? c : 32'd0);
      default: nv = v;
    endcase
  endtask

  task automatic model_reset();
    m_phase = 0; m_v = '0; m_beat = 0; m_frame = 0;
    m_ovf = 1'b0; m_drop = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_edge();
    logic [DW-1:0] nv;
    logic          no;
    m_done = 1'b0;
    case (m_phase)
      0: if (en) begin
        m_mode = cfg_mode; m_seed = cfg_seed; m_coef = cfg_coef;
        m_len = (cfg_frame_len == 16'd0) ? 1 : int'(cfg_frame_len);
        m_nfr = int'(cfg_num_frames); m_restart = cfg_restart;
        m_v = cfg_seed; m_beat = 0; m_frame = 0;
        m_ovf = 1'b0; m_drop = 1'b0; m_phase = 1;
      end
      1: begin
        if (!en) m_drop = 1'b1;
        if (ax.tready) begin
          next_val(m_mode, m_v, m_coef, nv, no);
          m_ovf = m_ovf | no;
          if (m_beat == m_len - 1) begin
            m_beat = 0;
            m_frame++;
            m_v = m_restart ? m_seed : nv;
            if (m_nfr != 0 && m_frame == m_nfr) begin
              m_phase = 2; m_done = 1'b1;
            end else if (m_drop) begin
              m_phase = 0;
            end
            m_drop = 1'b0;
          end else begin
            m_beat++;
            m_v = nv;
          end
        end
      end
      default: if (!en) m_phase = 0;
    endcase
  endtask

  task automatic check_outputs();
    logic ev;
    ev = (m_phase == 1);
    chk("tvalid", 32'(ax.tvalid), 32'(ev));
    if (ev) chk("tdata", ax.tdata, m_v);
    chk("tlast", 32'(ax.tlast), 32'(ev && (m_beat == m_len - 1)));
    chk("tstrb", 32'(ax.tstrb), ev ? 32'hF : 32'h0);
    chk("busy", 32'(busy), 32'(ev));
    chk("done", 32'(done), 32'(m_done));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tvalid"}, 32'(ax.tvalid), 32'd0);
    chk({tag, "_tdata"}, ax.tdata, 32'd0);
    chk({tag, "_tstrb"}, 32'(ax.tstrb), 32'd0);
    chk({tag, "_tlast"}, 32'(ax.tlast), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  // One clock: compare at the falling edge, log transfers, advance model.
  task automatic step();
    check_outputs();
    if (ax.tvalid === 1'b1 && ax.tready === 1'b1) begin
      got_q.push_back(ax.tdata);
      got_l.push_back(ax.tlast);
    end
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_seq(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_v.size()));
    for (int i = 0; i < exp_v.size() && i < got_q.size(); i++) begin
      chk({tag, "_data"}, got_q[i], exp_v[i]);
      chk({tag, "_last"}, 32'(got_l[i]), 32'(exp_l[i]));
    end
  endtask

  task automatic set_cfg(input logic [1:0] mode, input logic [31:0] seed,
                         input logic [31:0] coef, input int len, input int nfr,
                         input logic rs);
    cfg_mode = mode; cfg_seed = seed; cfg_coef = coef;
    cfg_frame_len = 16'(len); cfg_num_frames = 16'(nfr); cfg_restart = rs;
  endtask

  task automatic rand_cfg();
    cfg_mode       = 2'($urandom_range(3));
    cfg_seed       = $urandom;
    cfg_coef       = $urandom;
    cfg_frame_len  = 16'($urandom_range(6));
    cfg_num_frames = 16'($urandom_range(3));
    cfg_restart    = 1'($urandom_range(1));
  endtask

  // Bounded run with full throughput until finished, then release enable.
  task automatic run_bounded();
    int cyc;
    got_q.delete(); got_l.delete();
    en = 1'b1; ax.tready = 1'b1;
    cyc = 0;
    do begin step(); cyc++; end while (m_phase != 2 && cyc < 200);
    step();
    step();
    en = 1'b0;
    step();
    step();
  endtask

  initial begin
    int cyc;
    int drop_at;
    int pct;

    rst_n = 1'b0; en = 1'b0; ax.tready = 1'b0;
    set_cfg(2'b00, 32'd0, 32'd0, 0, 0, 1'b0);
    model_reset();
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Basic geometric
    set_cfg(2'b00, 32'd1, 32'd3, 4, 1, 1'b0);
    run_bounded();
    exp_v = '{32'd1, 32'd3, 32'd9, 32'd27};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
    chk_seq("geo");

    // Backpressure on the value-9 beat
    set_cfg(2'b00, 32'd1, 32'd3, 4, 1, 1'b0);
    got_q.delete(); got_l.delete();
    en = 1'b1; ax.tready = 1'b1;
    step();
    step();
    step();
    ax.tready = 1'b0;
    repeat (3) begin
      chk("bp_hold_data", ax.tdata, 32'd9);
      chk("bp_hold_valid", 32'(ax.tvalid), 32'd1);
      step();
    end
    ax.tready = 1'b1;
    cyc = 0;
    while (m_phase != 2 && cyc < 50) begin step(); cyc++; end
    step();
    en = 1'b0;
    step();
    step();
    chk_seq("bp");

    // Arithmetic carry-out
    set_cfg(2'b01, 32'hFFFF_FFFE, 32'd1, 3, 1, 1'b0);
    run_bounded();
    exp_v = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
    exp_l = '{1'b0, 1'b0, 1'b1};
    chk_seq("arith");
    chk("arith_ovf_sticky", 32'(overflow), 32'd1);

    // Restart vs continue
    set_cfg(2'b01, 32'd10, 32'd5, 2, 2, 1'b1);
    run_bounded();
    exp_v = '{32'd10, 32'd15, 32'd10, 32'd15};
    exp_l = '{1'b0, 1'b1, 1'b0, 1'b1};
    chk_seq("restart1");
    set_cfg(2'b01, 32'd10, 32'd5, 2, 2, 1'b0);
    run_bounded();
    exp_v = '{32'd10, 32'd15, 32'd20, 32'd25};
    chk_seq("restart0");

    // Frame length 0 acts as 1: tlast on every beat
    set_cfg(2'b11, 32'h0000_00A5, 32'd7, 0, 3, 1'b0);
    run_bounded();
    exp_v = '{32'hA5, 32'hA5, 32'hA5};
    exp_l = '{1'b1, 1'b1, 1'b1};
    chk_seq("len0");

    // LFSR, unbounded, enable dropped during beat 6
    set_cfg(2'b10, 32'h1, 32'hB4BC_D35C, 4, 0, 1'b0);
    got_q.delete(); got_l.delete();
    en = 1'b1; ax.tready = 1'b1;
    cyc = 0;
    while (got_q.size() < 5 && cyc < 50) begin step(); cyc++; end
    en = 1'b0;
    cyc = 0;
    while (m_phase != 0 && cyc < 50) begin step(); cyc++; end
    step();
    step();
    chk("lfsr_count", 32'(got_q.size()), 32'd8);
    if (got_q.size() == 8) begin
      chk("lfsr_b1", got_q[0], 32'h0000_0001);
      chk("lfsr_b2", got_q[1], 32'hB4BC_D35C);
      chk("lfsr_b3", got_q[2], 32'h5A5E_69AE);
      chk("lfsr_last4", 32'(got_l[3]), 32'd1);
      chk("lfsr_last7", 32'(got_l[6]), 32'd0);
      chk("lfsr_last8", 32'(got_l[7]), 32'd1);
    end
    chk("lfsr_idle_busy", 32'(busy), 32'd0);

    // Reset mid-frame, then a clean restart from the seed
    set_cfg(2'b00, 32'd1, 32'd3, 4, 1, 1'b0);
    got_q.delete(); got_l.delete();
    en = 1'b1; ax.tready = 1'b1;
    cyc = 0;
    while (got_q.size() < 1 && cyc < 20) begin step(); cyc++; end
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    got_q.delete(); got_l.delete();
    cyc = 0;
    do begin step(); cyc++; end while (m_phase != 2 && cyc < 50);
    step();
    en = 1'b0;
    step();
    step();
    exp_v = '{32'd1, 32'd3, 32'd9, 32'd27};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
    chk_seq("after_rst");

    // Randomized runs with backpressure, enable drops and cfg churn
    for (int r = 0; r < 30; r++) begin
      rand_cfg();
      en = 1'b1;
      drop_at = $urandom_range(40, 3);
      pct = $urandom_range(100, 30);
      for (int c = 0; c < 600; c++) begin
        if (c == drop_at) en = 1'b0;
        ax.tready = ($urandom_range(99) < pct);
        step();
        rand_cfg();
        if (c > drop_at && m_phase == 0) break;
      end
      chk("rand_end_busy", 32'(busy), 32'd0);
      chk("rand_end_valid", 32'(ax.tvalid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_seq_generator.md
# axis_seq_generator

Parametrised AXI4-Stream master that produces configurable numeric sequences (geometric, arithmetic, Galois LFSR, constant) in framed bursts with correct `tlast` and full `tvalid`/`tready` backpressure. It is the successor to the fixed power-of-3 source and feeds downstream stream consumers and checkers in the lab datapath. Configuration is latched at the start of each run, and a run is a programmable number of frames.

## Interface
- `DATA_SIZE`, 32: stream data width in bits; a multiple of 8, minimum 8.
- `LEN_W`, 16: width of the frame-length and frame-count configuration inputs.

- `m00_axis_aclk` in 1: clock; all logic on the rising edge.
- `m00_axis_aresetn` in 1: reset, asynchronous assert and active-low; deassertion is synchronised externally.
- `m00_axis_enable` in 1: run request, level-sensitive.
- `cfg_mode` in 2: sequence mode; 00 geometric, 01 arithmetic, 10 LFSR, 11 constant.
- `cfg_seed` in DATA_SIZE: first value of the sequence.
- `cfg_coef` in DATA_SIZE: multiplier (mode 00), step (mode 01) or tap polynomial (mode 10).
- `cfg_frame_len` in LEN_W: beats per frame; 0 is treated as 1.
- `cfg_num_frames` in LEN_W: frames per run; 0 means unbounded.
- `cfg_restart` in 1: 1 reloads the seed at each frame start; 0 continues the sequence across frames.
- `m00_axis_tready` in 1: downstream ready.
- `m00_axis_tdata` out DATA_SIZE: sequence value.
- `m00_axis_tstrb` out DATA_SIZE/8: all ones whenever `tvalid` is high.
- `m00_axis_tvalid` out 1: beat valid.
- `m00_axis_tlast` out 1: high on the last beat of each frame.
- `busy` out 1: high in the STREAM state.
- `done` out 1: one-cycle pulse after the final beat of a bounded run.
- `overflow` out 1: sticky; cleared only by reset or by run start.

## Operation
- States: IDLE, STREAM, DONE.
- **IDLE:**
  - Transition: if `enable`=1, latch all `cfg_*` inputs, clear `overflow` and go to STREAM.
  - First beat: `tdata`=seed, beat index 0, frame index 0.
- **STREAM:**
  - A beat transfers when `tvalid` and `tready` are both 1.
  - On each transfer:
    - Advance the value `v` by mode:
      - Geometric: `v*coef`, truncated to DATA_SIZE bits.
      - Arithmetic: `v+coef`, modulo 2^DATA_SIZE.
      - LFSR: `(v>>1) ^ (v[0] ? coef : 0)`.
      - Constant: `v` unchanged.
    - Increment the beat index.
  - `tlast` is 1 when beat index = frame_len-1.
  - On a `tlast` transfer:
    - Beat index returns to 0 and the frame index increments.
    - If restart=1, the next value is the seed instead of `f(v)`.
- **Overflow:**
  - Geometric: set on any transfer whose full-width product has nonzero bits above DATA_SIZE-1.
  - Arithmetic: set on carry-out.
  - LFSR and constant: never set.
  - Sequence generation continues after overflow.
- **Run end, bounded:** on the `tlast` transfer of frame num_frames-1, go to DONE and pulse `done`.
- **Run end, enable drop:** if `enable` drops mid-frame, the current frame is completed. On its `tlast` transfer, go to IDLE with no `done` pulse (this applies to unbounded runs as well).
- **DONE:** `tvalid`=0. Stay in DONE while `enable`=1 (no retrigger); return to IDLE when `enable`=0.
- **Config changes:** changes to `cfg_*` during a run have no effect until the next IDLE→STREAM transition.

## Timing
- Reset (asynchronous): IDLE, `tdata`=0, `tstrb`=0, `tvalid`=0, `tlast`=0, `busy`=0, `done`=0, `overflow`=0, counters 0.
- Start latency: `enable` sampled high at edge k gives `tvalid`=1 and `tdata`=seed after edge k.
- Throughput: one beat per cycle while `tready`=1, with no bubbles between frames.
- Backpressure:
  - Once asserted, `tvalid` stays high until transfer.
  - `tdata` and `tlast` are stable while `tvalid`=1 and `tready`=0.
  - `tvalid` never depends combinationally on `tready`; all outputs are registered.
- After the final transfer:
  - `tvalid`=0 and `tlast`=0 on the next cycle.
  - `done`=1 for exactly that cycle.
- frame_len=1: `tlast`=1 on every beat.
- Reset mid-frame: all outputs take their reset values immediately. No partial frame resumes after reset release.
- Simultaneous `enable` fall and `tlast` transfer: go to IDLE; a bounded run whose final frame this is goes to DONE with a `done` pulse.

## Test plan
- **Basic geometric:** mode 00, seed 1, coef 3, len 4, frames 1, `tready`=1 → beats 1, 3, 9, 27, with `tlast` on 27, `done` pulse next cycle, then DONE until `enable` falls.
- **Backpressure:** same config, `tready` low for 3 cycles while beat 3 (value 9) is valid → `tdata`=9 and `tvalid`=1 held for those 3 cycles, then sequence 27 follows.
- **Arithmetic overflow:** mode 01, seed 0xFFFFFFFE, coef 1, len 3, frames 1 → beats 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000. `overflow` rises on the second transfer and stays high after `done`.
- **Restart vs continue:** mode 01, seed 10, coef 5, len 2, frames 2:
  - restart=1 → 10, 15, 10, 15.
  - restart=0 → 10, 15, 20, 25.
  - `tlast` on the 2nd and 4th beats in both cases.
- **LFSR and enable drop:** mode 10, seed 0x1, coef 0xB4BCD35C, frames 0, len 4. Drop `enable` during beat 6 → frame 2 completes on beat 8 with `tlast`, then IDLE with no `done` pulse. Beats 1–3 are 0x1, 0xB4BCD35C, 0x5A5E69AE.
- **Reset mid-frame:** assert `aresetn`=0 during beat 2 of any run → all outputs go to zero in the same cycle. After release with `enable`=1, the next run restarts from the seed with beat index 0.
